fpu_int_to_float: RTL

Iterative signed 32-bit integer to IEEE-754 single-precision converter, executing op_int_to_float for the FPU arithmetic sequencer. The arith FSM hands it operand A with a start pulse, waits for done, captures float_out as the result, then acks. Normalisation is a shift-per-cycle loop, optionally accelerated by byte shifts. Rounding is round-to-nearest-even.

---
 rtl/pa_fpu.sv | 15 +
 rtl/fpu_int_to_float.sv | 113 +++++++++++
 2 files changed

// File: rtl/pa_fpu.sv
// Shared FPU definitions: converter state encoding and exponent constants.
package pa_fpu;

  typedef enum logic [2:0] {
    i2f_idle_st,
    i2f_start_st,
    i2f_normalize_st,
    i2f_round_st,
    i2f_result_valid_st
  } e_i2f_st;

  localparam logic [7:0] FP_BIAS      = 8'd127;
  localparam logic [7:0] I2F_EXP_INIT = FP_BIAS + 8'd31;

endpackage

// File: rtl/fpu_int_to_float.sv
// Iterative signed 32-bit integer to IEEE-754 single converter, round-to-nearest-even.
//
// state               | meaning
// i2f_idle_st         | waiting for start, operand latched on accept
// i2f_start_st        | take sign and magnitude, exponent preset to 158
// i2f_normalize_st    | shift magnitude left until bit 31 is set
// i2f_round_st        | round to 24 bits, assemble result
// i2f_result_valid_st | done held high until ack
module fpu_int_to_float
  import pa_fpu::*;
#(
  parameter bit FAST_NORM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] int_in,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] float_out
);

  e_i2f_st     state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic [31:0] float_q, float_d;

  logic [31:0] mag_abs;
  logic        round_up;
  logic [23:0] frac_rnd;
  logic [7:0]  exp_rnd;

  assign mag_abs  = op_q[31] ? (~op_q + 32'd1) : op_q;
  assign round_up = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
  assign frac_rnd = {1'b0, mag_q[30:8]} + {23'd0, round_up};
  // An all-ones fraction that rounds up wraps to zero and carries into the exponent.
  assign exp_rnd  = exp_q + {7'd0, frac_rnd[23]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= i2f_idle_st;
      op_q    <= '0;
      mag_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      float_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      float_q <= float_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    float_d = float_q;
    unique case (state_q)
      i2f_idle_st: begin
        if (start) begin
          op_d    = int_in;
          state_d = i2f_start_st;
        end
      end
      i2f_start_st: begin
        sign_d = op_q[31];
        mag_d  = mag_abs;
        exp_d  = I2F_EXP_INIT;
        // Zero skips normalisation but still spends one cycle in round, giving +0.
        state_d = (mag_abs == 32'd0) ? i2f_round_st : i2f_normalize_st;
      end
      i2f_normalize_st: begin
        if (mag_q[31]) begin
          state_d = i2f_round_st;
        end else if (FAST_NORM && (mag_q[31:24] == 8'd0)) begin
          mag_d = {mag_q[23:0], 8'd0};
          exp_d = exp_q - 8'd8;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end
      i2f_round_st: begin
        if (mag_q == 32'd0) begin
          float_d = 32'd0;
        end else begin
          float_d = {sign_q, exp_rnd, frac_rnd[22:0]};
        end
        state_d = i2f_result_valid_st;
      end
      i2f_result_valid_st: begin
        if (ack) begin
          state_d = i2f_idle_st;
        end
      end
      default: state_d = i2f_idle_st;
    endcase
  end

  assign busy      = (state_q != i2f_idle_st);
  assign done      = (state_q == i2f_result_valid_st);
  assign float_out = float_q;

endmodule
